// File: rtl/instr_issue_if.sv
// Handshake bundle between the issue sequencer, instruction memory and the lane decode stage.
// slave is the sequencer side; master is the environment (memory, decode, control) side.
interface instr_issue_if #(
  parameter int LANES = 4,
  parameter int PC_W  = 10
);
  logic              start;
  logic [PC_W-1:0]   start_pc;
  logic [LANES-1:0]  lane_mask_in;
  logic              abort;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  logic [31:0]       instr_out [LANES];
  logic [LANES-1:0]  lane_mask;
  logic              issue_valid;
  logic              issue_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  start, start_pc, lane_mask_in, abort,
    input  imem_gnt, imem_rvalid, imem_rdata, issue_ready,
    output imem_req, imem_addr, instr_out, lane_mask, issue_valid, busy, done
  );

  modport master (
    output start, start_pc, lane_mask_in, abort,
    output imem_gnt, imem_rvalid, imem_rdata, issue_ready,
    input  imem_req, imem_addr, instr_out, lane_mask, issue_valid, busy, done
  );
endinterface

// File: rtl/instr_issue_ctrl.sv
// Fetch/issue sequencer: walks a PC through instruction memory with one request in flight,
// buffers words in a 2-deep FIFO and broadcasts the head word to every SIMD lane.
module instr_issue_ctrl #(
  parameter int         LANES   = 4,
  parameter int         PC_W    = 10,
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_issue_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [LANES-1:0] mask_reg, mask_next;
  logic             req_reg, req_next;
  logic             pend_reg, pend_next;
  logic [1:0]       count_reg, count_next;
  logic [31:0]      fifo_reg  [2];
  logic [31:0]      fifo_next [2];

  logic start_ok;
  logic flush;
  logic gnt_fire;
  logic resp_fire;
  logic resp_halt;
  logic push;
  logic pop;

  always_comb begin
    flush     = bus.abort && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));
    start_ok  = bus.start && !bus.abort && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    gnt_fire  = req_reg && bus.imem_gnt;
    resp_fire = pend_reg && bus.imem_rvalid;
    resp_halt = resp_fire && (bus.imem_rdata[31:26] == HALT_OP);
    push      = resp_fire && !resp_halt;
    pop       = (count_reg != 2'd0) && bus.issue_ready;
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    mask_next    = mask_reg;
    req_next     = req_reg;
    pend_next    = pend_reg;
    count_next   = count_reg;
    fifo_next[0] = fifo_reg[0];
    fifo_next[1] = fifo_reg[1];

    // Shift FIFO: entry 0 is always the head, so the lane outputs come straight from a flop.
    case ({push, pop})
      2'b10: begin
        if (count_reg == 2'd0) begin
          fifo_next[0] = bus.imem_rdata;
          count_next   = 2'd1;
        end else if (count_reg == 2'd1) begin
          fifo_next[1] = bus.imem_rdata;
          count_next   = 2'd2;
        end
      end
      2'b01: begin
        fifo_next[0] = fifo_reg[1];
        count_next   = count_reg - 2'd1;
      end
      2'b11: begin
        if (count_reg == 2'd1) begin
          fifo_next[0] = bus.imem_rdata;
        end else begin
          fifo_next[0] = fifo_reg[1];
          fifo_next[1] = bus.imem_rdata;
        end
      end
      default: begin
      end
    endcase

    if (gnt_fire) begin
      req_next  = 1'b0;
      pend_next = 1'b1;
      pc_next   = pc_reg + PC_W'(1);
    end
    if (resp_fire) begin
      pend_next = 1'b0;
    end

    // Looking at post-update pending/count lets a new request follow a response directly.
    if ((state_reg == ST_RUN) && !resp_halt && !req_next && !pend_next && (count_next < 2'd2)) begin
      req_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
      end
      ST_RUN: begin
        if (resp_halt) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_next == 2'd0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (start_ok) begin
      state_next = ST_RUN;
      pc_next    = bus.start_pc;
      mask_next  = bus.lane_mask_in;
      req_next   = 1'b1;
      pend_next  = 1'b0;
      count_next = 2'd0;
    end

    // Dropping the pending flag is what makes a late response after abort harmless.
    if (flush) begin
      state_next = ST_IDLE;
      req_next   = 1'b0;
      pend_next  = 1'b0;
      count_next = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      mask_reg    <= '0;
      req_reg     <= 1'b0;
      pend_reg    <= 1'b0;
      count_reg   <= 2'd0;
      fifo_reg[0] <= '0;
      fifo_reg[1] <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      mask_reg    <= mask_next;
      req_reg     <= req_next;
      pend_reg    <= pend_next;
      count_reg   <= count_next;
      fifo_reg[0] <= fifo_next[0];
      fifo_reg[1] <= fifo_next[1];
    end
  end

  assign bus.imem_req    = req_reg;
  assign bus.imem_addr   = pc_reg;
  assign bus.lane_mask   = mask_reg;
  assign bus.issue_valid = (count_reg != 2'd0);
  assign bus.busy        = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign bus.done        = (state_reg == ST_DONE);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign bus.instr_out[gi] = fifo_reg[0];
  end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl: a program table run in a loop, plus hand-written
// sequences for backpressure, abort, reset, and start/abort interaction.
module tb_instr_issue_ctrl;
  localparam int LANES = 4;
  localparam int PC_W  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_issue_if #(.LANES(LANES), .PC_W(PC_W)) bus();

  instr_issue_ctrl #(.LANES(LANES), .PC_W(PC_W), .HALT_OP(6'h3F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]  start_pc;
    logic [LANES-1:0] mask;
    logic [3:0][31:0] words;
    int               n_issue;
    logic [PC_W-1:0]  last_addr;
    int               rv_lat;
    int               ready_mode;
  } vec_t;

  vec_t vt [5];

  logic [31:0]     mem [1024];
  int              rv_lat     = 1;
  int              rv_cd      = 0;
  logic [31:0]     rv_data    = '0;
  int              ready_mode = 0;
  int              cyc        = 0;
  logic [31:0]     iss_q [$];
  int              iss_cyc_q [$];
  logic [PC_W-1:0] gnt_q [$];
  int              done_cnt = 0;
  int              lane_err = 0;
  int              stable_err = 0;
  int              done_busy_err = 0;
  logic            prev_stall = 1'b0;
  logic [31:0]     prev_word = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory responder, ready driver and issue monitor, all acting at the falling edge.
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.issue_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.imem_rvalid = 1'b0;
      if (rv_cd > 0) begin
        rv_cd--;
        if (rv_cd == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = rv_data;
        end
      end
      if (bus.imem_gnt) begin
        bus.imem_gnt = 1'b0;
      end else if (rst_n && bus.imem_req) begin
        bus.imem_gnt = 1'b1;
        gnt_q.push_back(bus.imem_addr);
        rv_data = mem[bus.imem_addr];
        rv_cd   = rv_lat;
      end
      case (ready_mode)
        0:       bus.issue_ready = 1'b1;
        1:       bus.issue_ready = cyc[0];
        default: bus.issue_ready = 1'b0;
      endcase
      if (rst_n) begin
        if (bus.issue_valid && bus.issue_ready) begin
          iss_q.push_back(bus.instr_out[0]);
          iss_cyc_q.push_back(cyc);
        end
        if (bus.issue_valid) begin
          for (int l = 1; l < LANES; l++) begin
            if (bus.instr_out[l] !== bus.instr_out[0]) lane_err++;
          end
        end
        if (prev_stall && bus.issue_valid && (bus.instr_out[0] !== prev_word)) stable_err++;
        if (bus.done) done_cnt++;
        if (bus.done && bus.busy) done_busy_err++;
      end
      prev_stall = bus.issue_valid && !bus.issue_ready;
      prev_word  = bus.instr_out[0];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic clear_logs();
    iss_q.delete();
    iss_cyc_q.delete();
    gnt_q.delete();
    done_cnt      = 0;
    lane_err      = 0;
    stable_err    = 0;
    done_busy_err = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end else begin
      $display("ok   %s: done after %0d cycles", name, n);
    end
  endtask

  task automatic wait_gnt(input string name, input int budget);
    int n;
    n = 0;
    while (gnt_q.size() == 0 && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(gnt_q.size()), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req),    32'd0);
    chk({tag, "_addr"},  32'(bus.imem_addr),   32'd0);
    chk({tag, "_valid"}, 32'(bus.issue_valid), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy),        32'd0);
    chk({tag, "_done"},  32'(bus.done),        32'd0);
    chk({tag, "_mask"},  32'(bus.lane_mask),   32'd0);
    for (int l = 0; l < LANES; l++) begin
      chk($sformatf("%s_lane%0d", tag, l), bus.instr_out[l], 32'd0);
    end
  endtask

  task automatic launch(input logic [PC_W-1:0] pc, input logic [LANES-1:0] mask);
    bus.start        = 1'b1;
    bus.start_pc     = pc;
    bus.lane_mask_in = mask;
    step();
    bus.start        = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t            v;
    logic [PC_W-1:0] a;
    string           t;
    v = vt[k];
    t = $sformatf("v%0d", k);
    for (int i = 0; i < 4; i++) begin
      a = v.start_pc + PC_W'(i);
      mem[a] = v.words[i];
    end
    rv_lat     = v.rv_lat;
    ready_mode = v.ready_mode;
    clear_logs();
    launch(v.start_pc, v.mask);
    wait_done({t, "_done"}, 200);
    step();
    step();
    chk({t, "_n_issue"}, 32'(iss_q.size()), 32'(v.n_issue));
    for (int i = 0; i < v.n_issue && i < iss_q.size(); i++) begin
      chk($sformatf("%s_issue%0d", t, i), iss_q[i], v.words[i]);
    end
    chk({t, "_n_fetch"}, 32'(gnt_q.size()), 32'(v.n_issue + 1));
    for (int i = 0; i < gnt_q.size(); i++) begin
      a = v.start_pc + PC_W'(i);
      chk($sformatf("%s_addr%0d", t, i), 32'(gnt_q[i]), 32'(a));
    end
    chk({t, "_last_addr"}, (gnt_q.size() > 0) ? 32'(gnt_q[gnt_q.size()-1]) : 32'hFFFF_FFFF,
        32'(v.last_addr));
    chk({t, "_lane_mask"}, 32'(bus.lane_mask), 32'(v.mask));
    chk({t, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({t, "_lanes_equal"}, 32'(lane_err), 32'd0);
    chk({t, "_done_not_busy"}, 32'(done_busy_err), 32'd0);
    chk({t, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({t, "_idle_valid"}, 32'(bus.issue_valid), 32'd0);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.start_pc     = '0;
    bus.lane_mask_in = '0;
    bus.abort        = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    //           start_pc  mask     words {w3, w2, w1, w0}                                   n  last    lat rdy
    vt[0] = '{10'h010, 4'b1011, {32'h0000_0000, 32'hFC00_0000, 32'h0800_0002, 32'h0400_0001}, 2, 10'h012, 1, 0};
    vt[1] = '{10'h3FF, 4'b0001, {32'h0000_0000, 32'h0000_0000, 32'hFC00_0000, 32'h0C00_0003}, 1, 10'h000, 1, 0};
    vt[2] = '{10'h100, 4'b1111, {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFC00_0000}, 0, 10'h100, 2, 0};
    vt[3] = '{10'h020, 4'b0110, {32'hFC00_00AA, 32'hF800_0006, 32'h1400_0005, 32'h1000_0004}, 3, 10'h023, 3, 1};
    vt[4] = '{10'h1FE, 4'b1000, {32'h0000_0000, 32'hFC00_0001, 32'h0000_0000, 32'hF7FF_FFFF}, 2, 10'h200, 1, 1};

    rst_n = 1'b0;
    repeat (3) step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    for (int k = 0; k < 5; k++) run_vec(k);

    // Backpressure: two words buffered, fetching stalls, then back-to-back drain.
    clear_logs();
    rv_lat     = 1;
    ready_mode = 2;
    mem[10'h040] = 32'h1C00_0008;
    mem[10'h041] = 32'h2000_0009;
    mem[10'h042] = 32'h2400_000A;
    mem[10'h043] = 32'hFC00_0000;
    launch(10'h040, 4'b1111);
    repeat (10) step();
    chk("bp_fetches", 32'(gnt_q.size()), 32'd2);
    chk("bp_req_low", 32'(bus.imem_req), 32'd0);
    chk("bp_valid", 32'(bus.issue_valid), 32'd1);
    chk("bp_head", bus.instr_out[0], 32'h1C00_0008);
    chk("bp_stable", 32'(stable_err), 32'd0);
    chk("bp_none_issued", 32'(iss_q.size()), 32'd0);
    ready_mode = 0;
    wait_done("bp_done", 100);
    step();
    chk("bp_n_issue", 32'(iss_q.size()), 32'd3);
    chk("bp_issue0", (iss_q.size() > 0) ? iss_q[0] : 32'hDEAD_BEEF, 32'h1C00_0008);
    chk("bp_issue1", (iss_q.size() > 1) ? iss_q[1] : 32'hDEAD_BEEF, 32'h2000_0009);
    chk("bp_issue2", (iss_q.size() > 2) ? iss_q[2] : 32'hDEAD_BEEF, 32'h2400_000A);
    chk("bp_back_to_back", (iss_cyc_q.size() > 1) ? 32'(iss_cyc_q[1] - iss_cyc_q[0]) : 32'hFFFF,
        32'd1);
    chk("bp_fetches_total", 32'(gnt_q.size()), 32'd4);

    // Abort one cycle after grant, with the response still in flight.
    clear_logs();
    rv_lat     = 4;
    ready_mode = 0;
    mem[10'h080] = 32'h4400_0011;
    mem[10'h081] = 32'hFC00_0000;
    launch(10'h080, 4'b1111);
    wait_gnt("ab_gnt_seen", 20);
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_req", 32'(bus.imem_req), 32'd0);
    chk("ab_valid", 32'(bus.issue_valid), 32'd0);
    repeat (6) step();
    chk("ab_late_not_pushed", 32'(bus.issue_valid), 32'd0);
    chk("ab_no_issue", 32'(iss_q.size()), 32'd0);
    chk("ab_no_refetch", 32'(gnt_q.size()), 32'd1);
    chk("ab_no_done", 32'(done_cnt), 32'd0);
    clear_logs();
    rv_lat = 1;
    mem[10'h0C0] = 32'h2800_000B;
    mem[10'h0C1] = 32'hFC00_0000;
    launch(10'h0C0, 4'b0011);
    wait_done("ab_restart_done", 100);
    chk("ab_restart_addr", (gnt_q.size() > 0) ? 32'(gnt_q[0]) : 32'hFFFF_FFFF, 32'h0C0);
    chk("ab_restart_issue", (iss_q.size() > 0) ? iss_q[0] : 32'hDEAD_BEEF, 32'h2800_000B);
    chk("ab_restart_n_issue", 32'(iss_q.size()), 32'd1);

    // Start while busy is ignored: pc and mask keep the running program's values.
    repeat (3) step();
    clear_logs();
    rv_lat = 3;
    mem[10'h200] = 32'h2C00_000C;
    mem[10'h201] = 32'h3000_000D;
    mem[10'h202] = 32'hFC00_0000;
    mem[10'h300] = 32'h4800_0000;
    launch(10'h200, 4'b0101);
    wait_gnt("sb_gnt_seen", 20);
    step();
    launch(10'h300, 4'b0000);
    chk("sb_mask_kept", 32'(bus.lane_mask), 32'b0101);
    wait_done("sb_done", 100);
    chk("sb_n_fetch", 32'(gnt_q.size()), 32'd3);
    chk("sb_addr1", (gnt_q.size() > 1) ? 32'(gnt_q[1]) : 32'hFFFF_FFFF, 32'h201);
    chk("sb_addr2", (gnt_q.size() > 2) ? 32'(gnt_q[2]) : 32'hFFFF_FFFF, 32'h202);
    chk("sb_issue1", (iss_q.size() > 1) ? iss_q[1] : 32'hDEAD_BEEF, 32'h3000_000D);

    // Start and abort together from IDLE: abort wins.
    repeat (3) step();
    clear_logs();
    rv_lat = 1;
    bus.abort = 1'b1;
    launch(10'h3A0, 4'b1111);
    bus.abort = 1'b0;
    chk("sa_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    chk("sa_req", 32'(bus.imem_req), 32'd0);
    chk("sa_no_fetch", 32'(gnt_q.size()), 32'd0);

    // Asynchronous reset mid-run with one word buffered.
    clear_logs();
    ready_mode = 2;
    mem[10'h050] = 32'h3400_000E;
    mem[10'h051] = 32'h3800_000F;
    mem[10'h052] = 32'h3C00_0010;
    mem[10'h053] = 32'hFC00_0000;
    launch(10'h050, 4'b1110);
    begin
      int n;
      n = 0;
      while (!bus.issue_valid && n < 20) begin
        step();
        n++;
      end
    end
    chk("rr_one_buffered", 32'(bus.issue_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rr_async");
    step();
    step();
    rst_n = 1'b1;
    ready_mode = 0;
    clear_logs();
    repeat (10) step();
    chk("rr_no_issue", 32'(iss_q.size()), 32'd0);
    chk("rr_no_fetch", 32'(gnt_q.size()), 32'd0);
    chk("rr_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
